// File: rtl/nios2vga_sysid_checker.sv
// -----------------------------------------------------------------------------
// nios2vga_sysid_checker
//
// Hardware self-test initiator for the system-ID slave. A start pulse launches
// two Avalon-MM reads, word 0 (ID) and then word 1 (build timestamp). Both are
// compared against build-time constants. The result is reported without
// involving the CPU, so a mismatched FPGA image or software image is caught
// before the VGA pipeline is enabled.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   synchronous, active-high reset
//   start            in   one-cycle pulse that begins a check sequence
//   avm_address      out  slave word address (0 = ID, 1 = timestamp)
//   avm_read         out  Avalon read strobe
//   avm_waitrequest  in   slave stall
//   avm_readdata     in   32-bit slave read data
//   busy             out  sequence in progress
//   done             out  one-cycle pulse at the end of a sequence
//   pass             out  sticky: both words matched and no timeout
//   timeout          out  sticky: a read stalled for too long
//   id_value         out  captured word 0
//   ts_value         out  captured word 1
//
// Every output is a flop. avm_readdata only reaches outputs through
// registers, so the slave data bus has no combinational path out.
// -----------------------------------------------------------------------------
module nios2vga_sysid_checker #(
    parameter longint unsigned EXP_ID         = 64'd0,
    parameter longint unsigned EXP_TIMESTAMP  = 64'd1390219128,
    parameter int unsigned     TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    // The expected words are compared as 32 bits. Wider parameter values
    // are truncated.
    localparam logic [31:0] EXP_ID_W = EXP_ID[31:0];
    localparam logic [31:0] EXP_TS_W = EXP_TIMESTAMP[31:0];

    // The read aborts at the edge where the stall count would reach
    // TIMEOUT_CYCLES. The strobe is therefore high for exactly TIMEOUT_CYCLES
    // stalled cycles. The abort test uses the registered count, one below
    // the limit.
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_ID,
        RD_TS,
        FINISH
    } state_t;

    state_t      state;
    logic [15:0] wait_cnt;
    logic        id_ok;
    logic        ts_ok;

    function automatic logic word_match(input logic [31:0] data,
                                        input logic [31:0] expected);
        return data == expected;
    endfunction

    // Saturating increment: the stall counter never wraps back to zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    function automatic logic stall_expired(input logic [15:0] value);
        return value >= STALL_LAST;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
            wait_cnt    <= 16'd0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    // id_value and ts_value keep the previous result until
                    // a new sequence overwrites them.
                    if (start) begin
                        state       <= RD_ID;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        busy        <= 1'b1;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        wait_cnt    <= 16'd0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                    end
                end

                RD_ID: begin
                    if (!avm_waitrequest) begin
                        // Keep avm_read high and switch straight to word 1.
                        // This gives back-to-back reads with no idle cycle.
                        id_value    <= avm_readdata;
                        id_ok       <= word_match(avm_readdata, EXP_ID_W);
                        wait_cnt    <= 16'd0;
                        avm_address <= 1'b1;
                        state       <= RD_TS;
                    end else if (stall_expired(wait_cnt)) begin
                        avm_read    <= 1'b0;
                        avm_address <= 1'b0;
                        timeout     <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        pass        <= 1'b0;
                        state       <= FINISH;
                    end else begin
                        wait_cnt <= sat_inc(wait_cnt);
                    end
                end

                RD_TS: begin
                    if (!avm_waitrequest) begin
                        // The outputs are registered, so the FINISH-cycle
                        // outputs (done, pass, busy low) are loaded at this
                        // edge. pass uses the live compare because ts_ok only
                        // updates at this same edge.
                        ts_value    <= avm_readdata;
                        ts_ok       <= word_match(avm_readdata, EXP_TS_W);
                        pass        <= id_ok && word_match(avm_readdata, EXP_TS_W);
                        wait_cnt    <= 16'd0;
                        avm_read    <= 1'b0;
                        avm_address <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= FINISH;
                    end else if (stall_expired(wait_cnt)) begin
                        avm_read    <= 1'b0;
                        avm_address <= 1'b0;
                        timeout     <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        pass        <= 1'b0;
                        state       <= FINISH;
                    end else begin
                        wait_cnt <= sat_inc(wait_cnt);
                    end
                end

                FINISH: begin
                    // done is cleared by the default above. A start pulse in
                    // this cycle is ignored.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios2vga_sysid_checker.sv
module tb_nios2vga_sysid_checker;

    localparam logic [31:0] EXP_TS = 32'h52DD0F78;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    nios2vga_sysid_checker #(
        .EXP_ID(64'd0),
        .EXP_TIMESTAMP(64'd1390219128),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .busy(busy),
        .done(done),
        .pass(pass),
        .timeout(timeout),
        .id_value(id_value),
        .ts_value(ts_value)
    );

    // Slave model: stalls stall_cfg cycles on each read, then returns data.
    logic [31:0] id_data = 32'd0;
    logic [31:0] ts_data = 32'd0;
    int stall_cfg = 0;
    int stall_cnt = 0;
    assign avm_waitrequest = avm_read && (stall_cnt < stall_cfg);
    assign avm_readdata    = avm_address ? ts_data : id_data;
    always @(posedge clock) begin
        if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
    end

    // Scoreboard records and bus monitor.
    typedef struct {
        int          cyc;
        logic        pass;
        logic        timeout;
        logic [31:0] id;
        logic [31:0] ts;
    } rec_t;
    rec_t exp_q[$];
    rec_t obs_q[$];

    int   rd0 = 0, rd1 = 0, rd_hi = 0, stall_err = 0;
    logic prev_stall = 1'b0;
    logic prev_addr  = 1'b0;
    always @(negedge clock) begin
        if (done === 1'b1)
            obs_q.push_back(rec_t'{cyc, pass, timeout, id_value, ts_value});
        if (avm_read === 1'b1) begin
            rd_hi <= rd_hi + 1;
            if (avm_waitrequest === 1'b0) begin
                if (avm_address) rd1 <= rd1 + 1;
                else rd0 <= rd0 + 1;
            end
        end
        if (prev_stall && avm_read === 1'b1 && avm_address !== prev_addr)
            stall_err <= stall_err + 1;
        prev_stall <= (avm_read === 1'b1) && avm_waitrequest;
        prev_addr  <= avm_address;
    end

    task automatic pulse_start(output int s);
        @(negedge clock);
        start = 1'b1;
        s = cyc;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Waits (bounded) for a done record, then pops the expected/observed pair.
    task automatic pop_pair(output bit got, output rec_t e, output rec_t o);
        for (int i = 0; i < 60; i++) begin
            if (obs_q.size() > 0) break;
            @(negedge clock);
        end
        got = obs_q.size() > 0;
        e = exp_q.pop_front();
        if (got) o = obs_q.pop_front();
        else o = rec_t'{-1, 1'bx, 1'bx, 32'hx, 32'hx};
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (avm_read !== 1'b0) begin errors++; $display("FAIL rst_read: got %b want 0", avm_read); end
        checks++; if (avm_address !== 1'b0) begin errors++; $display("FAIL rst_addr: got %b want 0", avm_address); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
        checks++; if (pass !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL rst_pass_to: got %b%b want 00", pass, timeout); end
        checks++; if (id_value !== 32'd0 || ts_value !== 32'd0) begin errors++; $display("FAIL rst_values: got %h %h want 0 0", id_value, ts_value); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_zero_wait;
        int s, r0, r1, rh, se;
        bit got;
        rec_t e, o;
        id_data = 32'd0; ts_data = EXP_TS; stall_cfg = 0;
        r0 = rd0; r1 = rd1; rh = rd_hi; se = stall_err;
        pulse_start(s);
        exp_q.push_back(rec_t'{s + 3, 1'b1, 1'b0, 32'd0, EXP_TS});
        pop_pair(got, e, o);
        checks++; if (!got) begin errors++; $display("FAIL zw_done_seen: got none want done pulse"); end
        checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL zw_done_cycle: got %0d want %0d", o.cyc, e.cyc); end
        checks++; if (o.pass !== e.pass || o.timeout !== e.timeout) begin errors++; $display("FAIL zw_pass_to: got %b%b want %b%b", o.pass, o.timeout, e.pass, e.timeout); end
        checks++; if (o.id !== e.id || o.ts !== e.ts) begin errors++; $display("FAIL zw_values: got %h %h want %h %h", o.id, o.ts, e.id, e.ts); end
        repeat (4) @(negedge clock);
        checks++; if (rd0 - r0 != 1 || rd1 - r1 != 1) begin errors++; $display("FAIL zw_reads: got %0d/%0d want 1/1", rd0 - r0, rd1 - r1); end
        checks++; if (rd_hi - rh != 2) begin errors++; $display("FAIL zw_read_cycles: got %0d want 2", rd_hi - rh); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL zw_single_done: got %0d extra want 0", obs_q.size()); end
        checks++; if (pass !== 1'b1 || ts_value !== EXP_TS) begin errors++; $display("FAIL zw_hold: got %b %h want 1 %h", pass, ts_value, EXP_TS); end
        checks++; if (stall_err != se) begin errors++; $display("FAIL zw_stable: got %0d want %0d", stall_err, se); end
    endtask

    task automatic test_ts_mismatch;
        int s;
        bit got;
        rec_t e, o;
        id_data = 32'd0; ts_data = 32'h52DD0F77; stall_cfg = 0;
        pulse_start(s);
        exp_q.push_back(rec_t'{s + 3, 1'b0, 1'b0, 32'd0, 32'h52DD0F77});
        pop_pair(got, e, o);
        checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL mm_done_cycle: got %0d want %0d", o.cyc, e.cyc); end
        checks++; if (o.pass !== e.pass || o.timeout !== e.timeout) begin errors++; $display("FAIL mm_pass_to: got %b%b want %b%b", o.pass, o.timeout, e.pass, e.timeout); end
        checks++; if (o.ts !== e.ts) begin errors++; $display("FAIL mm_ts: got %h want %h", o.ts, e.ts); end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_wait_states;
        int s, r0, r1, rh, se;
        bit got;
        rec_t e, o;
        id_data = 32'd0; ts_data = EXP_TS; stall_cfg = 3;
        r0 = rd0; r1 = rd1; rh = rd_hi; se = stall_err;
        pulse_start(s);
        exp_q.push_back(rec_t'{s + 9, 1'b1, 1'b0, 32'd0, EXP_TS});
        pop_pair(got, e, o);
        checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL ws_done_cycle: got %0d want %0d", o.cyc, e.cyc); end
        checks++; if (o.pass !== e.pass || o.timeout !== e.timeout) begin errors++; $display("FAIL ws_pass_to: got %b%b want %b%b", o.pass, o.timeout, e.pass, e.timeout); end
        repeat (3) @(negedge clock);
        checks++; if (rd_hi - rh != 8) begin errors++; $display("FAIL ws_read_cycles: got %0d want 8", rd_hi - rh); end
        checks++; if (rd0 - r0 != 1 || rd1 - r1 != 1) begin errors++; $display("FAIL ws_reads: got %0d/%0d want 1/1", rd0 - r0, rd1 - r1); end
        checks++; if (stall_err != se) begin errors++; $display("FAIL ws_stable: got %0d want %0d", stall_err, se); end
        stall_cfg = 0;
    endtask

    task automatic test_timeout;
        int s, r0, r1, rh;
        bit got;
        rec_t e, o;
        id_data = 32'hDEADBEEF; ts_data = 32'h0; stall_cfg = 1000;
        r0 = rd0; r1 = rd1; rh = rd_hi;
        pulse_start(s);
        exp_q.push_back(rec_t'{s + 5, 1'b0, 1'b1, 32'd0, EXP_TS});
        pop_pair(got, e, o);
        checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL to_done_cycle: got %0d want %0d", o.cyc, e.cyc); end
        checks++; if (o.pass !== e.pass || o.timeout !== e.timeout) begin errors++; $display("FAIL to_pass_to: got %b%b want %b%b", o.pass, o.timeout, e.pass, e.timeout); end
        checks++; if (o.id !== e.id || o.ts !== e.ts) begin errors++; $display("FAIL to_values: got %h %h want %h %h", o.id, o.ts, e.id, e.ts); end
        repeat (4) @(negedge clock);
        checks++; if (rd_hi - rh != 4) begin errors++; $display("FAIL to_read_cycles: got %0d want 4", rd_hi - rh); end
        checks++; if (rd0 - r0 != 0 || rd1 - r1 != 0) begin errors++; $display("FAIL to_reads: got %0d/%0d want 0/0", rd0 - r0, rd1 - r1); end
        checks++; if (obs_q.size() != 0 || timeout !== 1'b1) begin errors++; $display("FAIL to_single_done: got %0d extra to=%b want 0 to=1", obs_q.size(), timeout); end
        stall_cfg = 0;
    endtask

    task automatic test_busy_start;
        int s, r0, r1;
        bit got;
        rec_t e, o;
        id_data = 32'd0; ts_data = EXP_TS; stall_cfg = 2;
        r0 = rd0; r1 = rd1;
        pulse_start(s);
        exp_q.push_back(rec_t'{s + 7, 1'b1, 1'b0, 32'd0, EXP_TS});
        for (int i = 0; i < 20 && cyc < s + 5; i++) @(negedge clock);
        checks++; if (busy !== 1'b1 || avm_address !== 1'b1) begin errors++; $display("FAIL bs_in_rd_ts: got busy=%b addr=%b want 1 1", busy, avm_address); end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        pop_pair(got, e, o);
        checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL bs_done_cycle: got %0d want %0d", o.cyc, e.cyc); end
        checks++; if (o.pass !== e.pass) begin errors++; $display("FAIL bs_pass: got %b want %b", o.pass, e.pass); end
        repeat (10) @(negedge clock);
        checks++; if (obs_q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL bs_ignored: got %0d extra busy=%b want 0 0", obs_q.size(), busy); end
        checks++; if (rd0 - r0 != 1 || rd1 - r1 != 1) begin errors++; $display("FAIL bs_reads: got %0d/%0d want 1/1", rd0 - r0, rd1 - r1); end
        stall_cfg = 0;
    endtask

    task automatic test_reset_mid;
        int s;
        bit got;
        rec_t e, o;
        id_data = 32'd0; ts_data = EXP_TS; stall_cfg = 3;
        pulse_start(s);
        for (int i = 0; i < 20 && cyc < s + 6; i++) @(negedge clock);
        checks++; if (avm_read !== 1'b1 || avm_address !== 1'b1 || avm_waitrequest !== 1'b1) begin errors++; $display("FAIL rm_stalled: got rd=%b addr=%b wr=%b want 111", avm_read, avm_address, avm_waitrequest); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (avm_read !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rm_ctrl: got rd=%b busy=%b done=%b want 000", avm_read, busy, done); end
        checks++; if (pass !== 1'b0 || timeout !== 1'b0 || avm_address !== 1'b0) begin errors++; $display("FAIL rm_flags: got %b%b%b want 000", pass, timeout, avm_address); end
        checks++; if (id_value !== 32'd0 || ts_value !== 32'd0) begin errors++; $display("FAIL rm_values: got %h %h want 0 0", id_value, ts_value); end
        reset = 1'b0;
        stall_cfg = 0;
        repeat (10) @(negedge clock);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rm_no_done: got %0d want 0", obs_q.size()); end
        pulse_start(s);
        exp_q.push_back(rec_t'{s + 3, 1'b1, 1'b0, 32'd0, EXP_TS});
        pop_pair(got, e, o);
        checks++; if (o.cyc !== e.cyc || o.pass !== e.pass) begin errors++; $display("FAIL rm_rerun: got cyc=%0d pass=%b want cyc=%0d pass=%b", o.cyc, o.pass, e.cyc, e.pass); end
        checks++; if (o.ts !== e.ts) begin errors++; $display("FAIL rm_rerun_ts: got %h want %h", o.ts, e.ts); end
        repeat (3) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_ts_mismatch();
        test_wait_states();
        test_timeout();
        test_busy_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
